// File: rtl/systolic_result_collector.sv
// systolic_result_collector
//
// Purpose:
//   Consumes the skewed column sums leaving a systolic array frame,
//   re-aligns them into whole result rows, buffers the rows in a small
//   row FIFO and streams them out on a valid/ready interface.
//   storage_ready is high only when the FIFO can absorb one full tile,
//   so a tile is never started without guaranteed space.
//
// Optional feature:
//   COLLECTOR_RELU_EN - when defined, each element is clamped at FIFO
//   write time (negative -> 0, non-negative unchanged). No added latency.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high; clears all state
//   sum_in         skewed column sums, one DATA_SIZE word per column
//   sum_valid      high for MATRIX_SIZE consecutive cycles per tile
//   storage_ready  space for a full tile is guaranteed
//   row_data       de-skewed row at the FIFO head (0 when empty)
//   row_valid      FIFO not empty
//   row_ready      consumer accepts the head row
//   row_last       head row is the last row of its tile
//   overflow_err   sticky: a tile started without credit
//   protocol_err   sticky: sum_valid gap in CAPTURE or sum_valid in FLUSH
//   state_dbg      current FSM state (IDLE=0, CAPTURE=1, FLUSH=2)
//   credits_dbg    current credit count (free rows not yet reserved)
//
// Handshake: a row transfers on every rising edge where row_valid and
// row_ready are both high. While row_valid is high and row_ready is low,
// row_data and row_last stay stable; row_valid never drops without a
// transfer (except on reset).

module systolic_result_collector #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] sum_in,
  input  logic                                  sum_valid,
  output logic                                  storage_ready,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_data,
  output logic                                  row_valid,
  input  logic                                  row_ready,
  output logic                                  row_last,
  output logic                                  overflow_err,
  output logic                                  protocol_err,
  output logic [1:0]                            state_dbg,
  output logic [$clog2(DEPTH+1)-1:0]            credits_dbg
);

  localparam int CW = $clog2(DEPTH + 1);   // credit / fill counter width
  localparam int AW = $clog2(DEPTH);       // FIFO pointer width
  localparam int BW = $clog2(MATRIX_SIZE); // beat / flush counter width

  typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------
  state_t          state, state_next;
  logic [BW-1:0]   cnt, cnt_next;
  logic            beat_ok;     // this beat belongs to an accepted tile
  logic            beat_last;   // this beat carries row N-1 in column 0
  logic            tile_start;
  logic            flush_done;
  logic            ovf_set;
  logic            prot_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    beat_ok    = 1'b0;
    beat_last  = 1'b0;
    tile_start = 1'b0;
    flush_done = 1'b0;
    ovf_set    = 1'b0;
    prot_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (sum_valid) begin
          if (storage_ready) begin
            // Beat 0 is consumed here, so CAPTURE starts counting at 1.
            beat_ok    = 1'b1;
            tile_start = 1'b1;
            cnt_next   = BW'(1);
            state_next = S_CAPTURE;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        if (sum_valid) begin
          beat_ok = 1'b1;
          if (cnt == BW'(MATRIX_SIZE - 1)) begin
            beat_last  = 1'b1;
            cnt_next   = '0;
            state_next = S_FLUSH;
          end else begin
            cnt_next = cnt + BW'(1);
          end
        end else begin
          // Truncated tile: rows never captured are simply not written;
          // their reserved credits come back at FLUSH exit.
          prot_set   = 1'b1;
          cnt_next   = '0;
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (sum_valid) prot_set = 1'b1;
        // N-1 cycles lets the longest column delay drain.
        if (cnt == BW'(MATRIX_SIZE - 2)) begin
          flush_done = 1'b1;
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + BW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // De-skew: column j lags column 0 by j cycles, so it is delayed by
  // N-1-j stages to line up with the last column. The beat valid and the
  // last-row flag travel through N-1 stages alongside.
  // ---------------------------------------------------------------------
  row_t aligned;

  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int DLY = MATRIX_SIZE - 1 - j;
    if (DLY == 0) begin : g_pass
      assign aligned[j] = sum_in[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] sr [DLY];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s < DLY; s++) sr[s] <= '0;
        end else begin
          sr[0] <= sum_in[j];
          for (int s = 1; s < DLY; s++) sr[s] <= sr[s-1];
        end
      end
      assign aligned[j] = sr[DLY-1];
    end
  end

  logic [MATRIX_SIZE-2:0] vld_dly;
  logic [MATRIX_SIZE-2:0] last_dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_dly  <= '0;
      last_dly <= '0;
    end else begin
      vld_dly[0]  <= beat_ok;
      last_dly[0] <= beat_last;
      for (int s = 1; s < MATRIX_SIZE - 1; s++) begin
        vld_dly[s]  <= vld_dly[s-1];
        last_dly[s] <= last_dly[s-1];
      end
    end
  end

  logic wr_en;
  logic wr_last;
  row_t wr_row;

  assign wr_en   = vld_dly[MATRIX_SIZE-2];
  assign wr_last = last_dly[MATRIX_SIZE-2];

  // Write-path element mux; the only difference between builds.
  always_comb begin
    wr_row = '0;
    for (int j = 0; j < MATRIX_SIZE; j++) begin
`ifdef COLLECTOR_RELU_EN
      wr_row[j] = aligned[j][DATA_SIZE-1] ? '0 : aligned[j];
`else
      wr_row[j] = aligned[j];
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Row FIFO (show-ahead: head entry is read straight from storage)
  // ---------------------------------------------------------------------
  row_t            mem_data [DEPTH];
  logic [DEPTH-1:0] mem_last;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic            push, pop;

  // Credit control makes a full-FIFO push impossible; the guard only
  // protects stored rows if that invariant were ever broken.
  assign push = wr_en && (fifo_count != CW'(DEPTH));
  assign pop  = row_valid && row_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= wr_row;
      mem_last[wr_ptr] <= wr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign row_valid = (fifo_count != '0);
  // Storage is not reset, so the outputs are forced to 0 while empty.
  assign row_data  = row_valid ? mem_data[rd_ptr] : '0;
  assign row_last  = row_valid ? mem_last[rd_ptr] : 1'b0;

  // ---------------------------------------------------------------------
  // Credits: free FIFO rows not yet reserved by a tile in flight
  // ---------------------------------------------------------------------
  logic [CW-1:0] credits, credits_next;
  logic [CW-1:0] rows_written;
  logic [CW-1:0] rows_total;

  // Includes a write landing on the FLUSH exit edge itself.
  assign rows_total = rows_written + CW'(wr_en);

  always_comb begin
    credits_next = credits;
    if (tile_start) credits_next = credits_next - CW'(MATRIX_SIZE);
    if (pop)        credits_next = credits_next + CW'(1);
    // Return the reservation for rows a truncated tile never produced.
    if (flush_done) credits_next = credits_next + (CW'(MATRIX_SIZE) - rows_total);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits      <= CW'(DEPTH);
      rows_written <= '0;
    end else begin
      credits <= credits_next;
      if (tile_start)  rows_written <= '0;
      else if (wr_en)  rows_written <= rows_written + CW'(1);
    end
  end

  assign storage_ready = (credits >= CW'(MATRIX_SIZE));
  assign credits_dbg   = credits;

  // ---------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (ovf_set)  overflow_err <= 1'b1;
      if (prot_set) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Testbench for systolic_result_collector (N=2, DATA_SIZE=32, DEPTH=4).
// Reference model: each accepted tile is expanded into its rows (with the
// optional clamp applied) and queued in exp_q; a negedge scoreboard checks
// every transferred row against the queue front. Credits are predicted as
// DEPTH minus the rows held or reserved in the model queue.

module tb_systolic_result_collector;

  localparam int N     = 2;
  localparam int D     = 32;
  localparam int DEPTH = 4;
  localparam int RW    = N * D + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [N-1:0][D-1:0] row_t;
  typedef logic [N-1:0][N-1:0][D-1:0] tile_t;   // tile[row][col]

  logic              clk;
  logic              reset;
  row_t              sum_in;
  logic              sum_valid;
  logic              storage_ready;
  row_t              row_data;
  logic              row_valid;
  logic              row_ready;
  logic              row_last;
  logic              overflow_err;
  logic              protocol_err;
  logic [1:0]        state_dbg;
  logic [CW-1:0]     credits_dbg;

  logic [RW-1:0]     exp_q[$];
  logic [RW-1:0]     sb_exp;
  int                n_checks = 0;
  int                n_fail   = 0;

`ifdef COLLECTOR_RELU_EN
  localparam logic [D-1:0] NEG5_OUT = 32'd0;
`else
  localparam logic [D-1:0] NEG5_OUT = 32'hFFFF_FFFB;
`endif

  systolic_result_collector #(
    .MATRIX_SIZE (N),
    .DATA_SIZE   (D),
    .DEPTH       (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sum_in        (sum_in),
    .sum_valid     (sum_valid),
    .storage_ready (storage_ready),
    .row_data      (row_data),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_last      (row_last),
    .overflow_err  (overflow_err),
    .protocol_err  (protocol_err),
    .state_dbg     (state_dbg),
    .credits_dbg   (credits_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic row_t model_row(input row_t r);
    row_t o;
    for (int j = 0; j < N; j++) begin
`ifdef COLLECTOR_RELU_EN
      o[j] = ($signed(r[j]) < 0) ? '0 : r[j];
`else
      o[j] = r[j];
`endif
    end
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && row_valid && row_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra_row: got last=%b data=%h, required no row", row_last, row_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({row_last, row_data} !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_row: got last=%b data=%h, required last=%b data=%h",
                   row_last, row_data, sb_exp[RW-1], sb_exp[RW-2:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    sum_valid = 1'b0;
    row_ready = 1'b0;
    sum_in    = '0;
    cyc();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Model credit decision; queue the tile's rows when accepted.
  task automatic reserve_tile(input tile_t t, output bit ok);
    ok = (DEPTH - int'(exp_q.size())) >= N;
    if (ok)
      for (int r = 0; r < N; r++)
        exp_q.push_back({(r == N - 1), model_row(t[r])});
  endtask

  // Inputs for skew cycle c: column j carries row c-j.
  task automatic drive_beat(input tile_t t, input int c, input bit flush_valid);
    sum_valid = (c < N) || (flush_valid && c == N);
    for (int j = 0; j < N; j++) begin
      if (c - j >= 0 && c - j < N) sum_in[j] = t[c-j][j];
      else                         sum_in[j] = $urandom();
    end
  endtask

  task automatic drive_tile(input tile_t t, input bit rand_ready, input bit flush_valid,
                            output bit ok);
    reserve_tile(t, ok);
    for (int c = 0; c < 2 * N - 1; c++) begin
      drive_beat(t, c, flush_valid);
      if (rand_ready) row_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    sum_valid = 1'b0;
  endtask

  task automatic rand_tile(output tile_t t);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        t[r][c] = D'(int'($urandom_range(0, 200)) - 100);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    row_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    cyc();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL reset_row_valid: got %b, required 0", row_valid); end
    n_checks++; if (row_last !== 1'b0) begin n_fail++; $display("FAIL reset_row_last: got %b, required 0", row_last); end
    n_checks++; if (row_data !== '0) begin n_fail++; $display("FAIL reset_row_data: got %h, required 0", row_data); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow_err); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_protocol: got %b, required 0", protocol_err); end
    n_checks++; if (storage_ready !== 1'b1) begin n_fail++; $display("FAIL reset_storage_ready: got %b, required 1", storage_ready); end
    n_checks++; if (credits_dbg !== CW'(DEPTH)) begin n_fail++; $display("FAIL reset_credits: got %0d, required %0d", credits_dbg, DEPTH); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", state_dbg); end
  endtask

  task automatic test_basic();
    tile_t t;
    bit ok;
    t[0][0] = 32'd1; t[0][1] = 32'd2; t[1][0] = 32'd3; t[1][1] = 32'd4;
    row_ready = 1'b1;
    reserve_tile(t, ok);
    drive_beat(t, 0, 1'b0);
    cyc();   // edge k
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b, required 0", row_valid); end
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL basic_state_capture: got %0d, required 1", state_dbg); end
    n_checks++; if (credits_dbg !== CW'(DEPTH - N)) begin n_fail++; $display("FAIL basic_credits_reserved: got %0d, required %0d", credits_dbg, DEPTH - N); end
    drive_beat(t, 1, 1'b0);
    cyc();   // edge k+1: row 0 written
    n_checks++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL basic_row0_valid: got %b, required 1", row_valid); end
    n_checks++; if (row_data !== {32'd2, 32'd1}) begin n_fail++; $display("FAIL basic_row0_data: got %h, required %h", row_data, {32'd2, 32'd1}); end
    n_checks++; if (row_last !== 1'b0) begin n_fail++; $display("FAIL basic_row0_last: got %b, required 0", row_last); end
    drive_beat(t, 2, 1'b0);
    cyc();   // edge k+2: row 0 popped, row 1 written
    sum_valid = 1'b0;
    n_checks++; if (row_data !== {32'd4, 32'd3}) begin n_fail++; $display("FAIL basic_row1_data: got %h, required %h", row_data, {32'd4, 32'd3}); end
    n_checks++; if (row_last !== 1'b1) begin n_fail++; $display("FAIL basic_row1_last: got %b, required 1", row_last); end
    cyc();
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b, required 0", row_valid); end
    n_checks++; if (credits_dbg !== CW'(DEPTH)) begin n_fail++; $display("FAIL basic_credits_back: got %0d, required %0d", credits_dbg, DEPTH); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL basic_state_idle: got %0d, required 0", state_dbg); end
  endtask

  task automatic test_backpressure();
    tile_t t;
    bit ok;
    row_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_tile(t);
      drive_tile(t, 1'b0, 1'b0, ok);
    end
    n_checks++; if (credits_dbg !== CW'(0)) begin n_fail++; $display("FAIL bp_credits_zero: got %0d, required 0", credits_dbg); end
    n_checks++; if (storage_ready !== 1'b0) begin n_fail++; $display("FAIL bp_not_ready: got %b, required 0", storage_ready); end
    rand_tile(t);
    drive_tile(t, 1'b0, 1'b0, ok);   // rejected by the model: no rows queued
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b, required 1", overflow_err); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL bp_state_idle: got %0d, required 0", state_dbg); end
    n_checks++; if (credits_dbg !== CW'(0)) begin n_fail++; $display("FAIL bp_credits_held: got %0d, required 0", credits_dbg); end
    row_ready = 1'b1;
    cyc();
    n_checks++; if (storage_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after_1pop: got %b, required 0", storage_ready); end
    cyc();
    n_checks++; if (storage_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_2pop: got %b, required 1", storage_ready); end
    drain(20);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d rows left, required 0", exp_q.size()); end
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL bp_fifo_empty: got %b, required 0", row_valid); end
    apply_reset();
  endtask

  task automatic test_gap();
    row_t r;
    r[0] = $urandom();
    r[1] = $urandom();
    row_ready = 1'b0;
    exp_q.push_back({1'b0, model_row(r)});
    sum_valid = 1'b1; sum_in[0] = r[0]; sum_in[1] = $urandom();
    cyc();
    sum_valid = 1'b0; sum_in[0] = $urandom(); sum_in[1] = r[1];
    cyc();
    cyc();
    n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL gap_protocol: got %b, required 1", protocol_err); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL gap_overflow: got %b, required 0", overflow_err); end
    n_checks++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL gap_row_valid: got %b, required 1", row_valid); end
    n_checks++; if ({row_last, row_data} !== {1'b0, model_row(r)}) begin n_fail++; $display("FAIL gap_row: got %h, required %h", {row_last, row_data}, {1'b0, model_row(r)}); end
    n_checks++; if (credits_dbg !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL gap_credits: got %0d, required %0d", credits_dbg, DEPTH - 1); end
    row_ready = 1'b1;
    cyc();
    row_ready = 1'b0;
    n_checks++; if (credits_dbg !== CW'(DEPTH)) begin n_fail++; $display("FAIL gap_credits_back: got %0d, required %0d", credits_dbg, DEPTH); end
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL gap_empty: got %b, required 0", row_valid); end
    apply_reset();
  endtask

  task automatic test_flush_valid();
    tile_t t;
    bit ok;
    rand_tile(t);
    drive_tile(t, 1'b0, 1'b1, ok);
    n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL flush_protocol: got %b, required 1", protocol_err); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL flush_state_idle: got %0d, required 0", state_dbg); end
    drain(20);
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_extra: got %b, required 0", row_valid); end
    n_checks++; if (credits_dbg !== CW'(DEPTH)) begin n_fail++; $display("FAIL flush_credits: got %0d, required %0d", credits_dbg, DEPTH); end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    row_ready = 1'b0;
    sum_valid = 1'b1; sum_in = {32'($urandom()), 32'($urandom())};
    cyc();
    sum_valid = 1'b0;
    cyc();
    cyc();   // one truncated row now buffered
    sum_valid = 1'b1;
    cyc();   // new tile in CAPTURE
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL rmid_state_capture: got %0d, required 1", state_dbg); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sum_valid = 1'b0;
    exp_q.delete();
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_row_valid: got %b, required 0", row_valid); end
    n_checks++; if (storage_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_storage_ready: got %b, required 1", storage_ready); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL rmid_protocol: got %b, required 0", protocol_err); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow: got %b, required 0", overflow_err); end
    n_checks++; if (credits_dbg !== CW'(DEPTH)) begin n_fail++; $display("FAIL rmid_credits: got %0d, required %0d", credits_dbg, DEPTH); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rmid_state: got %0d, required 0", state_dbg); end
    cyc();
    cyc();
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_inflight_discarded: got %b, required 0", row_valid); end
  endtask

  task automatic test_simul_pop_start();
    tile_t t;
    bit ok;
    row_ready = 1'b0;
    rand_tile(t);
    drive_tile(t, 1'b0, 1'b0, ok);
    n_checks++; if (credits_dbg !== CW'(DEPTH - N)) begin n_fail++; $display("FAIL simul_pre_credits: got %0d, required %0d", credits_dbg, DEPTH - N); end
    rand_tile(t);
    reserve_tile(t, ok);
    drive_beat(t, 0, 1'b0);
    row_ready = 1'b1;
    cyc();   // tile start and pop on the same edge
    n_checks++; if (credits_dbg !== CW'(DEPTH - N - N + 1)) begin n_fail++; $display("FAIL simul_credits: got %0d, required %0d", credits_dbg, DEPTH - 2 * N + 1); end
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL simul_accepted: got %0d, required 1", state_dbg); end
    for (int c = 1; c < 2 * N - 1; c++) begin
      drive_beat(t, c, 1'b0);
      cyc();
    end
    sum_valid = 1'b0;
    drain(20);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_drain: got %0d rows left, required 0", exp_q.size()); end
    n_checks++; if (credits_dbg !== CW'(DEPTH)) begin n_fail++; $display("FAIL simul_credits_back: got %0d, required %0d", credits_dbg, DEPTH); end
  endtask

  task automatic test_relu();
    tile_t t;
    bit ok;
    rand_tile(t);
    t[0][0] = 32'hFFFF_FFFB;   // -5
    t[0][1] = 32'd7;
    row_ready = 1'b0;
    drive_tile(t, 1'b0, 1'b0, ok);
    n_checks++; if (row_data[0] !== NEG5_OUT) begin n_fail++; $display("FAIL relu_neg: got %h, required %h", row_data[0], NEG5_OUT); end
    n_checks++; if (row_data[1] !== 32'd7) begin n_fail++; $display("FAIL relu_pos: got %h, required %h", row_data[1], 32'd7); end
    drain(20);
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL relu_drain: got %b, required 0", row_valid); end
  endtask

  task automatic test_back_to_back();
    tile_t t;
    bit ok;
    int tiles;
    tiles = 0;
    for (int i = 0; i < 40 && tiles < 12; i++) begin
      if ((DEPTH - int'(exp_q.size())) >= N) begin
        rand_tile(t);
        drive_tile(t, 1'b1, 1'b0, ok);
        tiles++;
      end else begin
        row_ready = 1'($urandom_range(0, 1));
        cyc();
      end
    end
    drain(40);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d rows left, required 0", exp_q.size()); end
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b, required 0", row_valid); end
    n_checks++; if (credits_dbg !== CW'(DEPTH)) begin n_fail++; $display("FAIL b2b_credits: got %0d, required %0d", credits_dbg, DEPTH); end
    n_checks++; if ({overflow_err, protocol_err} !== 2'b00) begin n_fail++; $display("FAIL b2b_errors: got %b, required 00", {overflow_err, protocol_err}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b1;
    sum_valid = 1'b0;
    row_ready = 1'b0;
    sum_in    = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_flush_valid();
    test_reset_mid();
    test_simul_pop_start();
    test_relu();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
